// File: rtl/dsc_mul_op_sequencer.sv
// Operand/result sequencer for the stochastic-computing multiplier engine:
// latches an operand set, clears and runs the engine, and returns the product.
module dsc_mul_op_sequencer #(
  parameter int unsigned DATA_WIDTH  = 5,
  parameter int unsigned NUM_INPUTS  = 2,
  parameter int unsigned OUT_WIDTH   = 10,
  parameter int unsigned CYC_W       = 16,
  parameter int unsigned TIMEOUT     = 1100,
  parameter int unsigned ZERO_BYPASS = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH*NUM_INPUTS-1:0] s_data,
  output logic                             eng_rst,
  output logic                             eng_en,
  output logic [DATA_WIDTH*NUM_INPUTS-1:0] eng_data_in,
  input  logic [OUT_WIDTH-1:0]             eng_data_out,
  input  logic                             eng_done,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [OUT_WIDTH-1:0]             m_data,
  output logic [CYC_W-1:0]                 m_cycles,
  output logic                             m_timeout
);

  localparam int unsigned IN_W = DATA_WIDTH * NUM_INPUTS;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;

  state_t               r_state;
  logic [IN_W-1:0]      r_op;
  logic [OUT_WIDTH-1:0] r_data;
  logic [CYC_W-1:0]     r_cycles;
  logic                 r_timeout;
  logic [CYC_W-1:0]     r_cnt;
  logic                 w_any_zero;
  logic                 w_bypass;

  // Any zero operand makes the product zero without running the engine.
  always_comb begin
    w_any_zero = 1'b0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (s_data[i*DATA_WIDTH +: DATA_WIDTH] == '0) w_any_zero = 1'b1;
    end
  end

  assign w_bypass = (ZERO_BYPASS != 0) && w_any_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_data    <= '0;
      r_cycles  <= '0;
      r_timeout <= 1'b0;
      r_cnt     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (s_valid) begin
            r_op      <= s_data;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
            if (w_bypass) begin
              r_data   <= '0;
              r_cycles <= '0;
              r_state  <= HOLD;
            end else begin
              r_state  <= CLEAR;
            end
          end
        end
        CLEAR: begin
          // Counter holds N during the N-th RUN cycle.
          r_cnt   <= CYC_W'(1);
          r_state <= RUN;
        end
        RUN: begin
          if (eng_done) begin
            r_data   <= eng_data_out;
            r_cycles <= r_cnt;
            r_state  <= HOLD;
          end else if (r_cnt == CYC_W'(TIMEOUT)) begin
            r_data    <= '0;
            r_cycles  <= r_cnt;
            r_timeout <= 1'b1;
            r_state   <= HOLD;
          end else begin
            r_cnt <= r_cnt + CYC_W'(1);
          end
        end
        HOLD: begin
          if (m_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Strobes decode from the registered state; reset forces the engine clear.
  assign s_ready     = (r_state == IDLE);
  assign eng_rst     = rst || (r_state == CLEAR);
  assign eng_en      = !rst && (r_state == RUN);
  assign m_valid     = !rst && (r_state == HOLD);
  assign eng_data_in = r_op;
  assign m_data      = r_data;
  assign m_cycles    = r_cycles;
  assign m_timeout   = r_timeout;

endmodule

// File: tb/tb_dsc_mul_op_sequencer.sv
// Directed bench for dsc_mul_op_sequencer with a behavioural counting engine.
module tb_dsc_mul_op_sequencer;

  logic        clk;
  logic        rst;
  logic        s_valid;
  logic        s_ready;
  logic [9:0]  s_data;
  logic        eng_rst;
  logic        eng_en;
  logic [9:0]  eng_data_in;
  logic [9:0]  eng_data_out;
  logic        eng_done;
  logic        m_valid;
  logic        m_ready;
  logic [9:0]  m_data;
  logic [15:0] m_cycles;
  logic        m_timeout;

  int errors = 0;
  int checks = 0;

  // Engine model: counts enabled cycles since its clear, done in enabled cycle done_at.
  int          done_at = 0;
  logic [15:0] eng_cnt;

  always @(posedge clk) begin
    if (eng_rst)     eng_cnt <= '0;
    else if (eng_en) eng_cnt <= eng_cnt + 16'd1;
  end

  assign eng_done     = eng_en && (done_at != 0) && (int'(eng_cnt) == done_at - 1);
  assign eng_data_out = 10'(eng_data_in[4:0]) * 10'(eng_data_in[9:5]);

  dsc_mul_op_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .eng_rst      (eng_rst),
    .eng_en       (eng_en),
    .eng_data_in  (eng_data_in),
    .eng_data_out (eng_data_out),
    .eng_done     (eng_done),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_cycles     (m_cycles),
    .m_timeout    (m_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of the last wait_valid call.
  int lat;
  int rst_cnt;
  int en_cnt;
  int din_chg;

  // Present an operand set and return at the negedge of the cycle after acceptance.
  task automatic send_op(input logic [9:0] d);
    bit ok;
    ok = 0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 20; i++) begin
      if (s_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (ok) begin
      @(negedge clk);
    end else begin
      errors++;
      $display("FAIL send_op: s_ready never rose within 20 cycles (data %h)", d);
    end
    s_valid = 1'b0;
  endtask

  // Wait for m_valid counting cycles after accept, and observe engine strobes.
  task automatic wait_valid(input int budget);
    logic [9:0] ref_din;
    lat = 1; rst_cnt = 0; en_cnt = 0; din_chg = 0;
    ref_din = eng_data_in;
    forever begin
      if (eng_rst) rst_cnt++;
      if (eng_en) en_cnt++;
      if (eng_data_in !== ref_din) din_chg++;
      if (m_valid || lat >= budget) break;
      @(negedge clk);
      lat++;
    end
    checks++;
    if (m_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid: m_valid not seen within %0d cycles", budget);
    end
  endtask

  task automatic take_result();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL take_result: m_valid=%b s_ready=%b, required 0 and 1", m_valid, s_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; done_at = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (eng_rst !== 1'b1 || eng_en !== 1'b0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_active: eng_rst=%b eng_en=%b m_valid=%b, required 1 0 0", eng_rst, eng_en, m_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || eng_en !== 1'b0 || eng_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: s_ready=%b m_valid=%b eng_en=%b eng_rst=%b, required 1 0 0 0", s_ready, m_valid, eng_en, eng_rst);
    end
    checks++;
    if (m_data !== 10'd0 || m_cycles !== 16'd0 || m_timeout !== 1'b0 || eng_data_in !== 10'd0) begin
      errors++;
      $display("FAIL reset_data: m_data=%0d m_cycles=%0d m_timeout=%b eng_data_in=%h, required all 0", m_data, m_cycles, m_timeout, eng_data_in);
    end
  endtask

  task automatic test_normal();
    done_at = 1024;
    send_op({5'd5, 5'd12});
    wait_valid(1200);
    checks++;
    if (lat !== 1026) begin
      errors++; $display("FAIL normal_latency: got %0d required 1026", lat);
    end
    checks++;
    if (m_data !== 10'd60 || m_cycles !== 16'd1024 || m_timeout !== 1'b0) begin
      errors++;
      $display("FAIL normal_result: m_data=%0d m_cycles=%0d m_timeout=%b, required 60 1024 0", m_data, m_cycles, m_timeout);
    end
    checks++;
    if (rst_cnt !== 1 || en_cnt !== 1024 || din_chg !== 0) begin
      errors++;
      $display("FAIL normal_engine: eng_rst cycles=%0d eng_en cycles=%0d din changes=%0d, required 1 1024 0", rst_cnt, en_cnt, din_chg);
    end
    take_result();
  endtask

  task automatic test_bypass();
    done_at = 0;
    send_op({5'd0, 5'd17});
    wait_valid(20);
    checks++;
    if (lat !== 1 || m_data !== 10'd0 || m_cycles !== 16'd0 || m_timeout !== 1'b0) begin
      errors++;
      $display("FAIL bypass_result: lat=%0d m_data=%0d m_cycles=%0d m_timeout=%b, required 1 0 0 0", lat, m_data, m_cycles, m_timeout);
    end
    checks++;
    if (rst_cnt !== 0 || en_cnt !== 0) begin
      errors++; $display("FAIL bypass_engine: eng_rst cycles=%0d eng_en cycles=%0d, required 0 0", rst_cnt, en_cnt);
    end
    take_result();
  endtask

  task automatic test_timeout();
    done_at = 0;
    send_op({5'd3, 5'd3});
    wait_valid(1200);
    checks++;
    if (lat !== 1102 || m_timeout !== 1'b1 || m_cycles !== 16'd1100 || m_data !== 10'd0) begin
      errors++;
      $display("FAIL timeout_abort: lat=%0d m_timeout=%b m_cycles=%0d m_data=%0d, required 1102 1 1100 0", lat, m_timeout, m_cycles, m_data);
    end
    take_result();
    done_at = 1100;
    send_op({5'd7, 5'd6});
    wait_valid(1200);
    checks++;
    if (lat !== 1102 || m_timeout !== 1'b0 || m_cycles !== 16'd1100 || m_data !== 10'd42) begin
      errors++;
      $display("FAIL timeout_done_wins: lat=%0d m_timeout=%b m_cycles=%0d m_data=%0d, required 1102 0 1100 42", lat, m_timeout, m_cycles, m_data);
    end
    take_result();
  endtask

  task automatic test_back_to_back();
    int bad;
    done_at = 4;
    send_op({5'd3, 5'd2});
    wait_valid(20);
    checks++;
    if (lat !== 6 || m_data !== 10'd6 || m_cycles !== 16'd4) begin
      errors++; $display("FAIL bp_first: lat=%0d m_data=%0d m_cycles=%0d, required 6 6 4", lat, m_data, m_cycles);
    end
    s_valid = 1'b1;
    s_data  = {5'd9, 5'd9};
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_valid !== 1'b1 || m_data !== 10'd6 || m_cycles !== 16'd4 ||
          s_ready !== 1'b0 || eng_data_in !== {5'd3, 5'd2}) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL bp_hold: %0d unstable cycles, required 0", bad);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release: s_ready=%b m_valid=%b, required 1 0", s_ready, m_valid);
    end
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (eng_data_in !== {5'd9, 5'd9} || eng_rst !== 1'b1 || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: eng_data_in=%h eng_rst=%b s_ready=%b, required 129 1 0", eng_data_in, eng_rst, s_ready);
    end
    wait_valid(20);
    checks++;
    if (lat !== 6 || m_data !== 10'd81 || m_cycles !== 16'd4) begin
      errors++; $display("FAIL bp_second: lat=%0d m_data=%0d m_cycles=%0d, required 6 81 4", lat, m_data, m_cycles);
    end
    take_result();
  endtask

  task automatic test_reset_midrun();
    done_at = 0;
    send_op({5'd4, 5'd4});
    repeat (300) @(negedge clk);
    checks++;
    if (eng_en !== 1'b1 || eng_rst !== 1'b0) begin
      errors++; $display("FAIL midrun_running: eng_en=%b eng_rst=%b, required 1 0", eng_en, eng_rst);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (eng_rst !== 1'b1 || eng_en !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset: eng_rst=%b eng_en=%b m_valid=%b s_ready=%b, required 1 0 0 1", eng_rst, eng_en, m_valid, s_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (eng_rst !== 1'b0 || eng_en !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL midrun_after: eng_rst=%b eng_en=%b m_valid=%b, required 0 0 0", eng_rst, eng_en, m_valid);
    end
    done_at = 256;
    send_op({5'd7, 5'd3});
    wait_valid(300);
    checks++;
    if (lat !== 258 || m_data !== 10'd21 || m_cycles !== 16'd256 || m_timeout !== 1'b0) begin
      errors++;
      $display("FAIL midrun_next_op: lat=%0d m_data=%0d m_cycles=%0d m_timeout=%b, required 258 21 256 0", lat, m_data, m_cycles, m_timeout);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bypass();
    test_timeout();
    test_back_to_back();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
